regfile_ab_latch: RTL
=====================

Name: regfile_ab_latch

Overview:
- Register file consuming the 5-bit write-destination address produced by the rt/rd destination select, plus the write-back data.
- Holds 32 general registers; $0 is hardwired to zero.
- Sources two read operands into multicycle A/B operand latches, with same-cycle write-to-read bypass.
- Sits between instruction decode (rs/rt fields), the write-back select path, and the ALU input muxes of the multicycle datapath.

Parameters:
- DATA_WIDTH, 32, register and data width in bits.
- ADDR_WIDTH, 5, register address width (2**ADDR_WIDTH registers).
- CNT_WIDTH, 16, width of the saturating committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- rs_addr  input  ADDR_WIDTH  read port A address (instruction rs field).
- rt_addr  input  ADDR_WIDTH  read port B address (instruction rt field).
- ab_load  input  1  when 1, A/B latches capture the port A/B read values this edge.
- reg_write  input  1  write enable for the write-back port.
- wr_addr  input  ADDR_WIDTH  write destination (rt or rd, from the destination select).
- wr_data  input  DATA_WIDTH  write-back data.
- a_out  output  DATA_WIDTH  A operand latch.
- b_out  output  DATA_WIDTH  B operand latch.
- dbg_addr  input  ADDR_WIDTH  debug read address.
- dbg_data  output  DATA_WIDTH  combinational debug read of the array; no bypass.
- wr_count  output  CNT_WIDTH  count of committed writes.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - All 32 registers, a_out, b_out and wr_count are cleared to 0.
  - The reset edge has priority over any write or load in the same cycle.
  - A reset asserted mid-instruction discards pending operands; there is no partial state.
- Write commit:
  - Occurs on a rising edge with rst_n=1, reg_write=1 and wr_addr!=0: reg[wr_addr] <= wr_data.
  - A write with wr_addr=0 is ignored, and reg[0] always reads 0.
- wr_count:
  - Increments by 1 on each committed write only; ignored writes to $0 do not count.
  - Saturates at all-ones; no wrap-around.
- Read value (combinational, internal):
  - rdA = 0 if rs_addr=0.
  - Otherwise rdA = wr_data if reg_write=1 and wr_addr==rs_addr (bypass).
  - Otherwise rdA = reg[rs_addr].
  - rdB is formed the same way from rt_addr.
- A/B latches:
  - On a rising edge with ab_load=1: a_out <= rdA, b_out <= rdB.
  - When ab_load=0 they hold their values.
  - Latency is 1 clock from address presentation to a_out/b_out.
- Simultaneous events:
  - A write and an ab_load to the same address in the same cycle: the latch captures the new wr_data (bypass).
  - rs_addr==rt_addr: both latches capture the same value.
  - A write to $0 combined with a load of $0: the latch captures 0.
- Debug port:
  - dbg_data = reg[dbg_addr], with reg[0] reading 0.
  - It reflects a write only after the commit edge.
- No X propagation from uninitialised storage: every register is reset.

Test Plan:
- Reset then load: rst_n=0 for 2 cycles, then ab_load=1 with rs=5, rt=31 -> a_out=0, b_out=0, wr_count=0.
- Write/readback: write reg[7]=0xDEADBEEF, next cycle ab_load with rs=7, rt=0 -> a_out=0xDEADBEEF, b_out=0, dbg_data(7)=0xDEADBEEF, wr_count=1.
- $0 protection: reg_write=1, wr_addr=0, wr_data=0xFFFFFFFF, then load rs=0 -> a_out=0, wr_count unchanged, dbg_data(0)=0.
- Bypass: the same cycle has reg_write=1, wr_addr=9, wr_data=0x12345678, ab_load=1, rs=9, rt=9 -> a_out=b_out=0x12345678 after the edge; in the prior cycle dbg_data(9) shows the old value.
- Hold and reset mid-operation: load a_out=0x55 and hold with ab_load=0 over 5 writes to other registers -> a_out stays 0x55; then rst_n=0 together with reg_write=1 -> all registers, a_out and wr_count are 0, and the write is dropped.
- Counter saturation with CNT_WIDTH=4: 20 committed writes -> wr_count=0xF and it stays 0xF.

Source files
------------

// File: rtl/regfile_ab_latch_if.sv
// Bus bundle between decode/write-back and the register file: read/write
// addresses, write-back data, A/B operand latches and the debug read port.
interface regfile_ab_latch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    logic [ADDR_WIDTH-1:0] rs_addr;
    logic [ADDR_WIDTH-1:0] rt_addr;
    logic                  ab_load;
    logic                  reg_write;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] a_out;
    logic [DATA_WIDTH-1:0] b_out;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_data;
    logic [CNT_WIDTH-1:0]  wr_count;

    modport master (
        output rs_addr, rt_addr, ab_load, reg_write, wr_addr, wr_data, dbg_addr,
        input  a_out, b_out, dbg_data, wr_count
    );

    modport slave (
        input  rs_addr, rt_addr, ab_load, reg_write, wr_addr, wr_data, dbg_addr,
        output a_out, b_out, dbg_data, wr_count
    );
endinterface

// File: rtl/regfile_ab_latch.sv
// 32-entry register file with $0 hardwired to zero, A/B operand latches fed
// through a same-cycle write bypass, a bypass-free debug read and a write counter.
module regfile_ab_latch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    regfile_ab_latch_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [0:NUM_REGS-1];
    logic [DATA_WIDTH-1:0] r_aOut;
    logic [DATA_WIDTH-1:0] r_bOut;
    logic [CNT_WIDTH-1:0]  r_wrCount;

    logic                  w_commit;
    logic                  w_cntSat;
    logic [DATA_WIDTH-1:0] w_rdA;
    logic [DATA_WIDTH-1:0] w_rdB;
    logic [DATA_WIDTH-1:0] w_dbgData;

    // Writes to $0 are dropped entirely, so they neither modify storage nor count.
    assign w_commit = bus.reg_write && (bus.wr_addr != '0);
    assign w_cntSat = (r_wrCount == '1);

    always_comb begin
        w_rdA = '0;
        w_rdB = '0;
        if (bus.rs_addr != '0) begin
            if (bus.reg_write && (bus.wr_addr == bus.rs_addr)) begin
                w_rdA = bus.wr_data;
            end else begin
                w_rdA = r_regs[bus.rs_addr];
            end
        end
        if (bus.rt_addr != '0) begin
            if (bus.reg_write && (bus.wr_addr == bus.rt_addr)) begin
                w_rdB = bus.wr_data;
            end else begin
                w_rdB = r_regs[bus.rt_addr];
            end
        end
    end

    // Debug port sees only committed contents.
    always_comb begin
        w_dbgData = '0;
        if (bus.dbg_addr != '0) begin
            w_dbgData = r_regs[bus.dbg_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_aOut    <= '0;
            r_bOut    <= '0;
            r_wrCount <= '0;
        end else begin
            if (w_commit) begin
                r_regs[bus.wr_addr] <= bus.wr_data;
            end
            if (bus.ab_load) begin
                r_aOut <= w_rdA;
                r_bOut <= w_rdB;
            end
            if (w_commit && !w_cntSat) begin
                r_wrCount <= r_wrCount + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.a_out    = r_aOut;
    assign bus.b_out    = r_bOut;
    assign bus.dbg_data = w_dbgData;
    assign bus.wr_count = r_wrCount;
endmodule
